// File: rtl/fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader_pkg
// Description : Shared types and constants for the fifo burst reader.
//               - state_t : reader FSM states (IDLE, READ, FLUSH, DONE)
//               - DEFAULT_BIT_WIDTH / DEFAULT_MAX_BURST : parameter defaults
//               - clamp_burst() : limits a requested burst to maxBurst
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_burst_reader_pkg;

  localparam int DEFAULT_BIT_WIDTH = 32;
  localparam int DEFAULT_MAX_BURST = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requests above the configured maximum are served as a maximum-size burst.
  function automatic int clamp_burst(input int len, input int max_burst);
    return (len > max_burst) ? max_burst : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader_if
// Description : Bus bundle of the fifo burst reader.
//               Fifo pop side : fifoEmpty, fifoPop, fifoPopData
//               Output stream : outValid, outReady, outData, outLast
//               master modport: the reader; slave modport: fifo + consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_burst_reader_if #(
  parameter int bitWidth = fifo_burst_reader_pkg::DEFAULT_BIT_WIDTH
) ();

  logic                fifoEmpty;
  logic                fifoPop;
  logic [bitWidth-1:0] fifoPopData;
  logic                outValid;
  logic                outReady;
  logic [bitWidth-1:0] outData;
  logic                outLast;

  modport master (
    input  fifoEmpty, fifoPopData, outReady,
    output fifoPop, outValid, outData, outLast
  );

  modport slave (
    output fifoEmpty, fifoPopData, outReady,
    input  fifoPop, outValid, outData, outLast
  );

endinterface
`default_nettype wire

// File: rtl/fifo_burst_reader_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader_skid
// Description : Two-entry output buffer (output register + one skid entry).
//               Ports: clock, reset, in_valid/in_data/in_last/in_ready
//               (in_ready = skid entry free), out_valid/out_ready/out_data/
//               out_last (stream side), empty (both entries free).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader_skid
  import fifo_burst_reader_pkg::*;
#(
  parameter int bitWidth = DEFAULT_BIT_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [bitWidth-1:0] in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bitWidth-1:0] out_data,
  output logic                out_last,
  output logic                empty
);

  logic                out_valid_q;
  logic [bitWidth-1:0] out_data_q;
  logic                out_last_q;
  logic                skid_valid;
  logic [bitWidth-1:0] skid_data;
  logic                skid_last;
  logic                accept;
  logic                xfer;

  // Accepting only while the skid entry is free keeps in_ready independent
  // of out_ready, so the upstream pop never sees a ready path.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & ~skid_valid;
  assign xfer     = out_valid_q & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_last   <= 1'b0;
    end else if (xfer) begin
      if (skid_valid) begin
        out_data_q <= skid_data;
        out_last_q <= skid_last;
        skid_valid <= 1'b0;
      end else if (accept) begin
        // Refill in the same cycle as the transfer: no bubble.
        out_data_q <= in_data;
        out_last_q <= in_last;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (out_valid_q) begin
        skid_data  <= in_data;
        skid_last  <= in_last;
        skid_valid <= 1'b1;
      end else begin
        out_data_q  <= in_data;
        out_last_q  <= in_last;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  // The last flag is meaningful only alongside valid data.
  assign out_last  = out_valid_q & out_last_q;
  assign empty     = ~out_valid_q & ~skid_valid;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Drains a burst of burstLength words from a first-word-fall-
//               through fifo onto a valid/ready stream with a last marker,
//               then pulses done for one cycle.
//               Ports: clock, reset (sync, active-high), start, burstLength,
//               busy, done, bus (fifo_burst_reader_if.master: fifo pop side
//               and output stream).
//               Optional: FIFO_BURST_READER_STALL_COUNT_EN adds stallCycles,
//               a saturating count of READ cycles spent waiting on an empty
//               fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int bitWidth = DEFAULT_BIT_WIDTH,
  parameter int maxBurst = DEFAULT_MAX_BURST,
  parameter int cntWidth = $clog2(maxBurst + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [cntWidth-1:0] burstLength,
  output logic                busy,
  output logic                done,
  fifo_burst_reader_if.master bus
`ifdef FIFO_BURST_READER_STALL_COUNT_EN
  ,
  output logic [31:0]         stallCycles
`endif
);

  state_t              state;
  state_t              state_next;
  logic [cntWidth-1:0] remaining;
  logic [cntWidth-1:0] start_len;
  logic                start_accept;
  logic                pop;
  logic                skid_ready;
  logic                buf_empty;

  assign start_len    = cntWidth'(clamp_burst(int'(burstLength), maxBurst));
  assign start_accept = (state == IDLE) & start;

  // Pop depends only on registered state and the fifo flag; outReady has no
  // combinational route to the fifo.
  assign pop         = (state == READ) & (remaining != '0) & ~bus.fifoEmpty & skid_ready;
  assign bus.fifoPop = pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (start_accept) begin
        remaining <= start_len;
      end else if (pop) begin
        remaining <= remaining - cntWidth'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (start_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        // Leave on the edge that performs the final pop.
        if ((remaining == '0) || (pop && (remaining == cntWidth'(1)))) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (buf_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  fifo_burst_reader_skid #(
    .bitWidth (bitWidth)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (pop),
    .in_data   (bus.fifoPopData),
    .in_last   (remaining == cntWidth'(1)),
    .in_ready  (skid_ready),
    .out_valid (bus.outValid),
    .out_ready (bus.outReady),
    .out_data  (bus.outData),
    .out_last  (bus.outLast),
    .empty     (buf_empty)
  );

`ifdef FIFO_BURST_READER_STALL_COUNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (start_accept) begin
      stall_cnt <= '0;
    end else if ((state == READ) && (remaining != '0) && bus.fifoEmpty &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stallCycles = stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader. The fifo is a
//               queue owned by the bench; the expected stream of a burst is
//               the first min(len, maxBurst) words held by that fifo, last on
//               the final one, followed by a single done pulse.
//               Honours FIFO_BURST_READER_STALL_COUNT_EN for stallCycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;

  localparam int BW   = 32;
  localparam int MAXB = 256;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] burstLength;
  logic          busy;
  logic          done;
`ifdef FIFO_BURST_READER_STALL_COUNT_EN
  logic [31:0]   stallCycles;
`endif

  fifo_burst_reader_if #(.bitWidth(BW)) bus ();

  fifo_burst_reader #(
    .bitWidth (BW),
    .maxBurst (MAXB),
    .cntWidth (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .burstLength (burstLength),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
`ifdef FIFO_BURST_READER_STALL_COUNT_EN
    ,
    .stallCycles (stallCycles)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] fq[$];
  logic [BW-1:0] rx_data[$];
  logic          rx_last[$];
  int            rx_cycle[$];

  int cyc = 0, pops = 0, burst_pops = 0, burst_len = 0, inflight = 0;
  int done_cnt = 0, done_cycle = 0, model_stall = 0;
  int pop_empty_viol = 0, skid_viol = 0, stable_viol = 0;
  logic          prev_hold = 1'b0;
  logic [BW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic upd_fifo();
    bus.fifoEmpty   = (fq.size() == 0);
    bus.fifoPopData = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic clear_fifo();
    fq.delete();
    upd_fifo();
  endtask

  task automatic clear_stats();
    rx_data.delete(); rx_last.delete(); rx_cycle.delete();
    pops = 0; done_cnt = 0; pop_empty_viol = 0; skid_viol = 0; stable_viol = 0;
  endtask

  // One clock: observe mid-cycle, then apply the fifo pop just after the edge.
  task automatic tick();
    logic pop_now, xfer_now, rst_now;
    @(negedge clock);
    rst_now  = reset;
    xfer_now = bus.outValid && bus.outReady;
    pop_now  = bus.fifoPop;
    if (xfer_now) begin
      rx_data.push_back(bus.outData);
      rx_last.push_back(bus.outLast);
      rx_cycle.push_back(cyc);
    end
    if (prev_hold && (!bus.outValid || bus.outData !== prev_data || bus.outLast !== prev_last))
      stable_viol++;
    prev_hold = bus.outValid && !bus.outReady && !rst_now;
    prev_data = bus.outData;
    prev_last = bus.outLast;
    if (pop_now) begin
      pops++;
      if (fq.size() == 0) pop_empty_viol++;
      if (inflight >= 2) skid_viol++;
    end
    if (!rst_now && busy && !done && burst_pops < burst_len && bus.fifoEmpty) model_stall++;
    if (done) begin
      done_cnt++;
      done_cycle = cyc;
    end
    @(posedge clock);
    #1;
    if (rst_now) inflight = 0;
    else         inflight = inflight + int'(pop_now) - int'(xfer_now);
    if (pop_now) begin
      if (fq.size() > 0) void'(fq.pop_front());
      burst_pops++;
    end
    upd_fifo();
    cyc++;
  endtask

  task automatic drive_start(input int len);
    start       = 1'b1;
    burstLength = CW'(len);
    burst_len   = (len > MAXB) ? MAXB : len;
    burst_pops  = 0;
    model_stall = 0;
    tick();
    start = 1'b0;
  endtask

  // mode 0: always ready, 1: 1,0,0 repeating, 2: random.
  task automatic run_until_done(input int mode, input int budget, output bit got);
    int d0;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      case (mode)
        0:       bus.outReady = 1'b1;
        1:       bus.outReady = ((i % 3) == 0);
        default: bus.outReady = 1'($urandom_range(0, 1));
      endcase
      tick();
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; burstLength = '0; bus.outReady = 1'b0;
    clear_fifo();
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.outValid); end
    n_tests++; if (bus.outLast !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", bus.outLast); end
    n_tests++; if (bus.outData !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.outData); end
    n_tests++; if (bus.fifoPop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got %b want 0", bus.fifoPop); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit got;
    clear_fifo(); clear_stats();
    for (int i = 1; i <= 8; i++) fq.push_back(BW'(i));
    upd_fifo();
    drive_start(8);
    run_until_done(0, 60, got);
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", got); end
    n_tests++; if (rx_data.size() !== 8) begin n_fail++; $display("FAIL basic_count got %0d want 8", rx_data.size()); end
    for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
      n_tests++; if (rx_data[i] !== BW'(i + 1)) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, rx_data[i], i + 1); end
      n_tests++; if (rx_last[i] !== (i == 7)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", i, rx_last[i], i == 7); end
    end
    if (rx_data.size() == 8) begin
      n_tests++; if (rx_cycle[7] - rx_cycle[0] !== 7) begin n_fail++; $display("FAIL basic_span got %0d want 7", rx_cycle[7] - rx_cycle[0]); end
      n_tests++; if (done_cycle - rx_cycle[7] !== 2) begin n_fail++; $display("FAIL basic_done_lat got %0d want 2", done_cycle - rx_cycle[7]); end
    end
    bus.outReady = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (pops !== 8) begin n_fail++; $display("FAIL basic_pops got %0d want 8", pops); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
`ifdef FIFO_BURST_READER_STALL_COUNT_EN
    n_tests++; if (stallCycles !== 32'd0) begin n_fail++; $display("FAIL basic_stall got %0d want 0", stallCycles); end
`endif
  endtask

  task automatic test_backpressure();
    bit got;
    logic [BW-1:0] exp[$];
    clear_fifo(); clear_stats();
    for (int i = 0; i < 6; i++) begin
      exp.push_back(BW'($urandom));
      fq.push_back(exp[i]);
    end
    upd_fifo();
    bus.outReady = 1'b0;
    drive_start(4);
    run_until_done(1, 100, got);
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", got); end
    n_tests++; if (rx_data.size() !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      n_tests++; if (rx_data[i] !== exp[i]) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, rx_data[i], exp[i]); end
      n_tests++; if (rx_last[i] !== (i == 3)) begin n_fail++; $display("FAIL bp_last[%0d] got %b want %b", i, rx_last[i], i == 3); end
    end
    n_tests++; if (stable_viol !== 0) begin n_fail++; $display("FAIL bp_stable got %0d want 0", stable_viol); end
    n_tests++; if (skid_viol !== 0) begin n_fail++; $display("FAIL bp_pop_when_full got %0d want 0", skid_viol); end
    n_tests++; if (pops !== 4) begin n_fail++; $display("FAIL bp_pops got %0d want 4", pops); end
    n_tests++; if (fq.size() !== 2) begin n_fail++; $display("FAIL bp_fifo_left got %0d want 2", fq.size()); end
  endtask

  task automatic test_starve();
    bit got;
    int d0, busy_drop;
    logic [BW-1:0] exp[$];
    clear_fifo(); clear_stats();
    for (int i = 0; i < 5; i++) exp.push_back(BW'($urandom));
    fq.push_back(exp[0]); fq.push_back(exp[1]);
    upd_fifo();
    drive_start(5);
    d0 = done_cnt; busy_drop = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus.outReady = 1'b1;
      if (i == 10) begin
        for (int k = 2; k < 5; k++) fq.push_back(exp[k]);
        upd_fifo();
      end
      tick();
      if (done_cnt != d0) begin got = 1'b1; break; end
      if (!busy) busy_drop++;
    end
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL starve_done got %b want 1", got); end
    n_tests++; if (busy_drop !== 0) begin n_fail++; $display("FAIL starve_busy_drop got %0d want 0", busy_drop); end
    n_tests++; if (pop_empty_viol !== 0) begin n_fail++; $display("FAIL starve_pop_empty got %0d want 0", pop_empty_viol); end
    n_tests++; if (rx_data.size() !== 5) begin n_fail++; $display("FAIL starve_count got %0d want 5", rx_data.size()); end
    for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
      n_tests++; if (rx_data[i] !== exp[i]) begin n_fail++; $display("FAIL starve_data[%0d] got %h want %h", i, rx_data[i], exp[i]); end
      n_tests++; if (rx_last[i] !== (i == 4)) begin n_fail++; $display("FAIL starve_last[%0d] got %b want %b", i, rx_last[i], i == 4); end
    end
`ifdef FIFO_BURST_READER_STALL_COUNT_EN
    n_tests++; if (stallCycles !== 32'(model_stall)) begin n_fail++; $display("FAIL starve_stall got %0d want %0d", stallCycles, model_stall); end
    tick(); tick(); tick();
    n_tests++; if (stallCycles !== 32'(model_stall)) begin n_fail++; $display("FAIL starve_stall_hold got %0d want %0d", stallCycles, model_stall); end
`endif
  endtask

  task automatic test_zero_len();
    bit got;
    logic [BW-1:0] exp[$];
    clear_fifo(); clear_stats();
    for (int i = 0; i < 10; i++) begin
      exp.push_back(BW'($urandom));
      fq.push_back(exp[i]);
    end
    upd_fifo();
    bus.outReady = 1'b1;
    drive_start(0);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width got %b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy); end
    tick();
    n_tests++; if (pops !== 0) begin n_fail++; $display("FAIL zero_pops got %0d want 0", pops); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
    // A second start while busy must not restart or extend the burst.
    clear_stats();
    bus.outReady = 1'b0;
    drive_start(3);
    tick(); tick();
    start = 1'b1; burstLength = CW'(7);
    tick(); tick();
    start = 1'b0;
    run_until_done(0, 60, got);
    tick(); tick();
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL ign_done got %b want 1", got); end
    n_tests++; if (rx_data.size() !== 3) begin n_fail++; $display("FAIL ign_count got %0d want 3", rx_data.size()); end
    for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
      n_tests++; if (rx_data[i] !== exp[i]) begin n_fail++; $display("FAIL ign_data[%0d] got %h want %h", i, rx_data[i], exp[i]); end
    end
    n_tests++; if (pops !== 3) begin n_fail++; $display("FAIL ign_pops got %0d want 3", pops); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [BW-1:0] exp[$];
    clear_fifo(); clear_stats();
    for (int i = 0; i < 9; i++) fq.push_back(BW'($urandom));
    upd_fifo();
    bus.outReady = 1'b1;
    drive_start(6);
    for (int i = 0; i < 40 && rx_data.size() < 3; i++) tick();
    n_tests++; if (rx_data.size() !== 3) begin n_fail++; $display("FAIL rmid_pre_count got %0d want 3", rx_data.size()); end
    reset = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b want 0", done); end
    n_tests++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", bus.outValid); end
    n_tests++; if (bus.outLast !== 1'b0) begin n_fail++; $display("FAIL rmid_last got %b want 0", bus.outLast); end
    n_tests++; if (bus.outData !== '0) begin n_fail++; $display("FAIL rmid_data got %h want 0", bus.outData); end
    n_tests++; if (bus.fifoPop !== 1'b0) begin n_fail++; $display("FAIL rmid_pop got %b want 0", bus.fifoPop); end
    reset = 1'b0;
    tick();
    clear_stats();
    for (int i = 0; i < 3 && i < fq.size(); i++) exp.push_back(fq[i]);
    drive_start(3);
    run_until_done(0, 60, got);
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL rmid_done2 got %b want 1", got); end
    n_tests++; if (rx_data.size() !== exp.size()) begin n_fail++; $display("FAIL rmid_count got %0d want %0d", rx_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_data.size(); i++) begin
      n_tests++; if (rx_data[i] !== exp[i]) begin n_fail++; $display("FAIL rmid_data[%0d] got %h want %h", i, rx_data[i], exp[i]); end
    end
  endtask

  task automatic test_clamp();
    bit got;
    logic [BW-1:0] exp[$];
    clear_fifo(); clear_stats();
    for (int i = 0; i < MAXB + 5; i++) begin
      exp.push_back(BW'($urandom));
      fq.push_back(exp[i]);
    end
    upd_fifo();
    drive_start(MAXB + 5);
    run_until_done(2, 3000, got);
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL clamp_done got %b want 1", got); end
    n_tests++; if (rx_data.size() !== MAXB) begin n_fail++; $display("FAIL clamp_count got %0d want %0d", rx_data.size(), MAXB); end
    for (int i = 0; i < MAXB && i < rx_data.size(); i++) begin
      n_tests++; if (rx_data[i] !== exp[i]) begin n_fail++; $display("FAIL clamp_data[%0d] got %h want %h", i, rx_data[i], exp[i]); end
      n_tests++; if (rx_last[i] !== (i == MAXB - 1)) begin n_fail++; $display("FAIL clamp_last[%0d] got %b want %b", i, rx_last[i], i == MAXB - 1); end
    end
    n_tests++; if (pops !== MAXB) begin n_fail++; $display("FAIL clamp_pops got %0d want %0d", pops, MAXB); end
    n_tests++; if (fq.size() !== 5) begin n_fail++; $display("FAIL clamp_fifo_left got %0d want 5", fq.size()); end
    n_tests++; if (stable_viol !== 0) begin n_fail++; $display("FAIL clamp_stable got %0d want 0", stable_viol); end
  endtask

  task automatic test_random();
    bit got;
    int n, extra;
    logic [BW-1:0] exp[$];
    for (int it = 0; it < 4; it++) begin
      clear_fifo(); clear_stats();
      exp.delete();
      n     = $urandom_range(1, 40);
      extra = $urandom_range(0, 3);
      for (int i = 0; i < n + extra; i++) begin
        exp.push_back(BW'($urandom));
        fq.push_back(exp[i]);
      end
      upd_fifo();
      drive_start(n);
      run_until_done(2, 400, got);
      n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_done got %b want 1", it, got); end
      n_tests++; if (rx_data.size() !== n) begin n_fail++; $display("FAIL rnd%0d_count got %0d want %0d", it, rx_data.size(), n); end
      for (int i = 0; i < n && i < rx_data.size(); i++) begin
        n_tests++; if (rx_data[i] !== exp[i]) begin n_fail++; $display("FAIL rnd%0d_data[%0d] got %h want %h", it, i, rx_data[i], exp[i]); end
        n_tests++; if (rx_last[i] !== (i == n - 1)) begin n_fail++; $display("FAIL rnd%0d_last[%0d] got %b want %b", it, i, rx_last[i], i == n - 1); end
      end
      n_tests++; if (pops !== n) begin n_fail++; $display("FAIL rnd%0d_pops got %0d want %0d", it, pops, n); end
      n_tests++; if (stable_viol + skid_viol + pop_empty_viol !== 0) begin
        n_fail++; $display("FAIL rnd%0d_rules got stable=%0d skid=%0d empty=%0d want 0", it, stable_viol, skid_viol, pop_empty_viol);
      end
    end
  endtask

  initial begin
    bus.outReady    = 1'b0;
    bus.fifoEmpty   = 1'b1;
    bus.fifoPopData = '0;
    start           = 1'b0;
    burstLength     = '0;
    reset           = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_starve();
    test_zero_len();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
